// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the iterative shift-and-add multiplier.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  // Bits needed to count 0..width-1; never less than one bit.
  function automatic int unsigned count_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain ripple/inferred adder; carry-out is the caller's job (zero-extend inputs).
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/shift_add_multiplier.sv
// Multicycle shift-and-add multiplier: magnitude multiply over WIDTH cycles,
// then a single sign fixup; fixed latency of WIDTH+2 cycles.
module shift_add_multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = count_width(WIDTH);

  mult_state_t        state, state_next;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  logic [CW-1:0]      count;

  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     addend, sum;
  logic [2*WIDTH-1:0] raw;

  assign ready     = (state == IDLE) || (state == DONE);
  assign done      = (state == DONE);
  assign accept    = ready && start;
  assign last_step = (count == CW'(WIDTH - 1));

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign mag_b = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

  assign addend = mplr[0] ? {1'b0, mcand} : '0;
  assign raw    = {acc[WIDTH-1:0], mplr};

  adder #(.WIDTH(WIDTH + 1)) u_adder (
    .a   (acc),
    .b   (addend),
    .sum (sum)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      mplr    <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        acc   <= '0;
        mplr  <= mag_b;
        mcand <= mag_a;
        neg   <= is_signed && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        count <= '0;
      end else if (state == RUN) begin
        // {acc, mplr} <= {sum, mplr} >> 1
        acc   <= {1'b0, sum[WIDTH:1]};
        mplr  <= {sum[0], mplr[WIDTH-1:1]};
        count <= count + 1'b1;
      end
      if (state == FIXUP) begin
        product <= neg ? -raw : raw;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized and directed self-checking bench for shift_add_multiplier at WIDTH=8.
module tb_shift_add_multiplier;

  localparam int unsigned W = 8;

  logic           clock;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           done;
  logic [2*W-1:0] product;

  int checks;
  int errors;
  logic [2*W-1:0] prev_exp;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .done         (done),
    .product      (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: integer product of the operands as interpreted, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    int sa, sb, p;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Called at a cycle where the unit should be ready; returns in the DONE cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit disturb);
    logic [2*W-1:0] exp;
    int bad;
    exp = model(a, b, s);
    check("ready_accept", ready, 1);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    start        = 1'b1;
    step();
    start = 1'b0;
    bad   = 0;
    for (int c = 1; c <= W + 1; c++) begin
      if (c == 1) check("hold_prev", product, prev_exp);
      if (ready !== 1'b0 || done !== 1'b0) bad++;
      if (disturb && (c == 4 || c == W + 1)) begin
        start        = 1'b1;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        is_signed    = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("busy_cycles", bad, 0);
    check("done_pulse", done, 1);
    check("ready_in_done", ready, 1);
    check("product", product, exp);
    prev_exp = exp;
  endtask

  task automatic idle_check(input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (done !== 1'b0 || ready !== 1'b1) pulses++;
    end
    check("idle_quiet", pulses, 0);
    check("idle_hold", product, prev_exp);
  endtask

  initial begin
    int ndone;
    checks       = 0;
    errors       = 0;
    prev_exp     = '0;
    reset        = 1'b1;
    start        = 1'b0;
    is_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) step();
    reset = 1'b0;
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_product", product, 0);

    do_op(8'd13, 8'd11, 1'b0, 1'b0);
    idle_check(1);
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b1, 1'b0);
    do_op(8'hFD, 8'h05, 1'b1, 1'b0);
    idle_check(2);
    do_op(8'h00, 8'hFF, 1'b1, 1'b0);
    idle_check(1);

    do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    idle_check(W + 4);

    do_op(8'd7, 8'd9, 1'b0, 1'b0);
    do_op(8'd2, 8'd3, 1'b0, 1'b0);
    idle_check(1);

    // Reset mid-RUN together with a start request.
    multiplicand = 8'd100;
    multiplier   = 8'd50;
    is_signed    = 1'b0;
    start        = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reset        = 1'b1;
    start        = 1'b1;
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    step();
    reset = 1'b0;
    start = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    ndone = 0;
    for (int c = 0; c < W + 4; c++) begin
      step();
      if (done !== 1'b0) ndone++;
    end
    check("abort_no_done", ndone, 0);
    prev_exp = '0;
    do_op(8'd21, 8'd3, 1'b0, 1'b0);
    idle_check(1);

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle_check($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Iterative shift-and-add multiplier that uses a single adder for `WIDTH` cycles instead of instantiating a combinational array multiplier. A small FSM sequences the datapath. It accepts one operand pair per start/ready handshake and returns a `2*WIDTH`-bit product with fixed latency. It sits beside the ALU as the multicycle execution unit for MUL-class instructions; the core stalls on `ready`/`done`.

## Interface
- `WIDTH`, default 32: operand width; legal values are ≥ 2.
- `clock`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high.
- `start`  input  1: request; accepted only in a cycle with `ready` = 1.
- `is_signed`  input  1: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `multiplicand`  input  WIDTH: operand A; sampled with `start`.
- `multiplier`  input  WIDTH: operand B; sampled with `start`.
- `ready`  output  1: unit can accept `start` this cycle.
- `done`  output  1: one-cycle pulse; `product` is valid.
- `product`  output  2*WIDTH: result; held stable from `done` until the cycle after the next accepted start.

## Operation
- **States:** IDLE, RUN, FIXUP, DONE.
- **IDLE**
  - `ready` = 1.
  - On `start`:
    - Load `acc` (upper WIDTH+1 bits) = 0.
    - Load `mplr` (lower WIDTH bits) = |B|.
    - Load `mcand` = |A|.
    - Set `neg` = `is_signed` & (A[WIDTH-1] ^ B[WIDTH-1]).
    - Set `count` = 0.
    - Go to RUN.
  - In unsigned mode, |X| = X.
- **RUN**
  - Each cycle: `sum` = `acc` + (`mplr`[0] ? {1'b0, `mcand`} : 0), computed in WIDTH+1 bits.
  - Then {`acc`, `mplr`} = {`sum`, `mplr`} >> 1.
  - `count`++.
  - When `count` = WIDTH-1, go to FIXUP.
  - `start` is ignored.
- **FIXUP**
  - `product` register = `neg` ? -(lower 2*WIDTH of {`acc`, `mplr`}) : {`acc`, `mplr`}.
  - Negation is two's complement modulo 2^(2*WIDTH).
  - Go to DONE.
  - `start` is ignored.
- **DONE**
  - `done` = 1 and `ready` = 1.
  - If `start` is asserted: accept it exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- **Width rules**
  - Signed -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which is representable unsigned. No special case is needed.
  - The unsigned max product (2^WIDTH-1)^2 fits in 2*WIDTH bits. The adder carry is retained in `acc`[WIDTH].
- **Reset**
  - State = IDLE, `product` = 0, `done` = 0, `count` = 0, `neg` = 0.
  - Reset in any state aborts the operation. No `done` is issued for it.
  - Reset dominates a simultaneous `start`.

## Timing
- Cycle 0: `start` & `ready` sampled.
- Cycles 1..WIDTH: RUN (`ready` = 0).
- Cycle WIDTH+1: FIXUP.
- Cycle WIDTH+2: DONE (`done` = 1, `product` valid).
- Latency is a fixed WIDTH+2 cycles, independent of operand values and sign.
- Throughput is one result per WIDTH+2 cycles when `start` is asserted in DONE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- `product` changes only in FIXUP and on reset.

## Structure
- **Package `multiplier_pkg`:**
  - `mult_state_t` enum {IDLE, RUN, FIXUP, DONE}, 2 bits.
  - Counter width function/constant `$clog2(WIDTH)`.
- **Sub-module:** reuse the existing `adder` as `adder #(WIDTH+1)` for the accumulate step, with zero-extended inputs.
- Absolute value and final negate are local combinational logic.
- Registers use synchronous reset. Do not reuse the asynchronous-reset flop modules.

## Test plan
- WIDTH=8, unsigned, A=13, B=11 → `done` at cycle 10 after acceptance, `product` = 16'h008F, `ready` low for cycles 1–9.
- WIDTH=8, unsigned, A=8'hFF, B=8'hFF → `product` = 16'hFE01. Signed, A=8'h80, B=8'h80 → 16'h4000.
- WIDTH=8, signed, A=-3 (8'hFD), B=5 → 16'hFFF1. Signed, A=0, B=-1 → 16'h0000 (`neg` set, negate of 0 is 0).
- Pulse `start` with new operands during RUN and during FIXUP → ignored; first result unchanged; exactly one `done`.
- Assert `start` in DONE cycle with A=2, B=3 → previous `product` held through DONE, new `done` 10 cycles later with 16'h0006, and no IDLE cycle between.
- Assert `reset` at RUN cycle 4, together with `start` → next cycle IDLE, `product` = 0, `ready` = 1, no `done` pulse. A following operation completes normally.
